// File: rtl/seq_alu.sv
// Registered ALU with a start/busy/done handshake. Single-cycle ops finish on the
// accept edge; MUL/DIVU/REMU iterate one bit per cycle for WIDTH cycles.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       alu_funct,
  input  logic [WIDTH-1:0] data_rs,
  input  logic [WIDTH-1:0] data_rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   alu_res,
  output logic [4:0]       flags
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_REMU = 6'h1F;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      cnt;
  logic [5:0]         op;
  logic [WIDTH-1:0]   dvs;
  logic [2*WIDTH-1:0] acc;

  function automatic logic [4:0] mk_flags(input logic [WIDTH:0] r, input logic v,
                                          input logic dz, input logic ill);
    return {ill, dz, v, r[WIDTH-1], ~|r[WIDTH-1:0]};
  endfunction

  logic is_multi;
  assign is_multi = (alu_funct == FN_MUL) || (alu_funct == FN_DIVU) || (alu_funct == FN_REMU);

  // ---------------- single-cycle datapath (straight from the ports)
  logic [WIDTH:0]  add_r, sub_r, sc_res;
  logic            sc_v, sc_ill;
  logic [SW-1:0]   sh;

  assign sh    = data_rt[SW-1:0];
  assign add_r = {1'b0, data_rs} + {1'b0, data_rt};
  assign sub_r = {1'b0, data_rs} + {1'b0, ~data_rt} + (WIDTH+1)'(1);

  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (alu_funct)
      FN_ADD: begin
        sc_res = add_r;
        sc_v   = (data_rs[WIDTH-1] == data_rt[WIDTH-1]) && (add_r[WIDTH-1] != data_rs[WIDTH-1]);
      end
      FN_SUB: begin
        sc_res = sub_r;
        sc_v   = (data_rs[WIDTH-1] != data_rt[WIDTH-1]) && (sub_r[WIDTH-1] != data_rs[WIDTH-1]);
      end
      FN_AND:  sc_res = {1'b0, data_rs & data_rt};
      FN_OR:   sc_res = {1'b0, data_rs | data_rt};
      FN_XOR:  sc_res = {1'b0, data_rs ^ data_rt};
      FN_NOR:  sc_res = {1'b0, ~(data_rs | data_rt)};
      FN_SLT:  sc_res = {WIDTH'(0), $signed(data_rs) < $signed(data_rt)};
      FN_SLTU: sc_res = {WIDTH'(0), data_rs < data_rt};
      FN_SLL:  sc_res = {1'b0, data_rs << sh};
      FN_SRL:  sc_res = {1'b0, data_rs >> sh};
      FN_SRA:  sc_res = {1'b0, $unsigned($signed(data_rs) >>> sh)};
      FN_MUL, FN_DIVU, FN_REMU: ;
      default: sc_ill = 1'b1;
    endcase
  end

  // ---------------- iterative datapath
  // acc = {hi, lo}. MUL: hi accumulates, lo holds the multiplier shifting out.
  // DIV: hi is the partial remainder, lo shifts the dividend out and quotient in.
  logic [WIDTH:0]     m_sum, r_sh;
  logic [WIDTH+1:0]   d_diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] mul_nx, div_nx, acc_nx;
  logic [WIDTH:0]     mc_res;
  logic               mc_dz;

  assign m_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_nx = {m_sum, acc[WIDTH-1:1]};
  assign r_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign d_diff = {1'b0, r_sh} - {2'b00, dvs};
  assign ge     = ~d_diff[WIDTH+1];
  assign rem_nx = ge ? d_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign div_nx = {rem_nx, acc[WIDTH-2:0], ge};
  assign acc_nx = (op == FN_MUL) ? mul_nx : div_nx;
  assign mc_dz  = (op != FN_MUL) && (dvs == '0);

  always_comb begin
    mc_res = '0;
    case (op)
      FN_MUL:  mc_res = {|mul_nx[2*WIDTH-1:WIDTH], mul_nx[WIDTH-1:0]};
      FN_DIVU: mc_res = {1'b0, div_nx[WIDTH-1:0]};
      default: mc_res = {1'b0, div_nx[2*WIDTH-1:WIDTH]};
    endcase
  end

  // ---------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: state_nx = start ? (is_multi ? RUN : FIN) : IDLE;
      RUN:       if (cnt == '0) state_nx = FIN;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op      <= '0;
      dvs     <= '0;
      acc     <= '0;
      alu_res <= '0;
      flags   <= '0;
    end else begin
      case (state)
        IDLE, FIN: if (start) begin
          op  <= alu_funct;
          dvs <= data_rt;
          acc <= {{WIDTH{1'b0}}, data_rs};
          cnt <= SW'(WIDTH-1);
          if (!is_multi) begin
            alu_res <= sc_res;
            flags   <= mk_flags(sc_res, sc_v, 1'b0, sc_ill);
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - SW'(1);
          if (cnt == '0) begin
            alu_res <= mc_res;
            flags   <= mk_flags(mc_res, 1'b0, mc_dz, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for results/flags/latency, plus
// hand-written handshake, back-to-back and reset-abort sequences.
module tb_seq_alu;
  localparam int W = 32;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_REMU = 6'h1F;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_ILL  = 6'h3F;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [5:0]   alu_funct;
  logic [W-1:0] data_rs, data_rt;
  logic         busy, done;
  logic [W:0]   alu_res;
  logic [4:0]   flags;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_funct(alu_funct),
    .data_rs(data_rs), .data_rt(data_rt),
    .busy(busy), .done(done), .alu_res(alu_res), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W:0]   res;
    logic [4:0]   fl;
    int           lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (caller sits #1 after an edge); returns at the done sample.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit busy_ok);
    alu_funct = f; data_rs = a; data_rt = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  initial begin
    int  lat, ndone;
    bit  bok;

    vecs[0]  = '{FN_ADD,  32'd2,          32'd1,          33'h0_0000_0003, 5'h00, 1};
    vecs[1]  = '{FN_SUB,  32'd2,          32'd1,          33'h1_0000_0001, 5'h00, 1};
    vecs[2]  = '{FN_SUB,  32'd1,          32'd2,          33'h0_FFFF_FFFF, 5'h02, 1};
    vecs[3]  = '{FN_ADD,  32'h7FFF_FFFF,  32'd1,          33'h0_8000_0000, 5'h06, 1};
    vecs[4]  = '{FN_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  33'h0_F000_F000, 5'h02, 1};
    vecs[5]  = '{FN_OR,   32'h0F0F_0000,  32'h0000_00F0,  33'h0_0F0F_00F0, 5'h00, 1};
    vecs[6]  = '{FN_XOR,  32'hA5A5_A5A5,  32'hA5A5_A5A5,  33'h0_0000_0000, 5'h01, 1};
    vecs[7]  = '{FN_NOR,  32'h0,          32'h0,          33'h0_FFFF_FFFF, 5'h02, 1};
    vecs[8]  = '{FN_SLT,  32'hFFFF_FFFF,  32'd1,          33'h0_0000_0001, 5'h00, 1};
    vecs[9]  = '{FN_SLTU, 32'hFFFF_FFFF,  32'd1,          33'h0_0000_0000, 5'h01, 1};
    vecs[10] = '{FN_SLL,  32'd1,          32'h23,         33'h0_0000_0008, 5'h00, 1};
    vecs[11] = '{FN_SRL,  32'h8000_0000,  32'd31,         33'h0_0000_0001, 5'h00, 1};
    vecs[12] = '{FN_SRA,  32'h8000_0000,  32'd4,          33'h0_F800_0000, 5'h02, 1};
    vecs[13] = '{FN_MUL,  32'h0001_0000,  32'h0001_0000,  33'h1_0000_0000, 5'h01, 33};
    vecs[14] = '{FN_MUL,  32'd7,          32'd6,          33'h0_0000_002A, 5'h00, 33};
    vecs[15] = '{FN_DIVU, 32'd100,        32'd7,          33'h0_0000_000E, 5'h00, 33};
    vecs[16] = '{FN_REMU, 32'd100,        32'd7,          33'h0_0000_0002, 5'h00, 33};
    vecs[17] = '{FN_DIVU, 32'd5,          32'd0,          33'h0_FFFF_FFFF, 5'h0A, 33};
    vecs[18] = '{FN_REMU, 32'd5,          32'd0,          33'h0_0000_0005, 5'h08, 33};
    vecs[19] = '{FN_ILL,  32'd9,          32'd4,          33'h0_0000_0000, 5'h11, 1};

    rst = 1'b1; start = 1'b0; alu_funct = '0; data_rs = '0; data_rt = '0;
    tick(); tick();
    chk("reset busy",  64'(busy),    64'd0);
    chk("reset done",  64'(done),    64'd0);
    chk("reset res",   64'(alu_res), 64'd0);
    chk("reset flags", 64'(flags),   64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f, vecs[i].rs, vecs[i].rt, lat, bok);
      chk($sformatf("vec%0d latency", i), 64'(lat),      64'(vecs[i].lat));
      chk($sformatf("vec%0d busy", i),    64'(bok),      64'd1);
      chk($sformatf("vec%0d res", i),     64'(alu_res),  64'(vecs[i].res));
      chk($sformatf("vec%0d flags", i),   64'(flags),    64'(vecs[i].fl));
      tick();
      chk($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d hold", i),       64'(alu_res), 64'(vecs[i].res));
    end

    // start during busy with changed operands is dropped
    alu_funct = FN_MUL; data_rs = 32'd7; data_rt = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    alu_funct = FN_ADD; data_rs = 32'd1000; data_rt = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; data_rs = 32'd55; data_rt = 32'd11;
    lat = 7;
    while (!done && lat < 100) begin tick(); lat++; end
    chk("busy-drop latency", 64'(lat),     64'd33);
    chk("busy-drop res",     64'(alu_res), 64'h2A);
    ndone = 0;
    repeat (4) begin tick(); if (done) ndone++; end
    chk("busy-drop no queued done", 64'(ndone), 64'd0);

    // back-to-back: start in FIN cycle is accepted
    run_op(FN_DIVU, 32'd100, 32'd7, lat, bok);
    chk("b2b first res", 64'(alu_res), 64'hE);
    run_op(FN_ADD, 32'd2, 32'd1, lat, bok);
    chk("b2b single latency", 64'(lat),     64'd1);
    chk("b2b single res",     64'(alu_res), 64'h3);
    run_op(FN_REMU, 32'd100, 32'd7, lat, bok);
    chk("b2b multi latency", 64'(lat),     64'd33);
    chk("b2b multi res",     64'(alu_res), 64'h2);
    tick();

    // reset during RUN aborts with no done
    alu_funct = FN_DIVU; data_rs = 32'd100; data_rt = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("abort busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy",  64'(busy),    64'd0);
    chk("abort done",  64'(done),    64'd0);
    chk("abort res",   64'(alu_res), 64'd0);
    chk("abort flags", 64'(flags),   64'd0);
    ndone = 0;
    repeat (40) begin tick(); if (done || busy) ndone++; end
    chk("abort no done", 64'(ndone), 64'd0);

    // rst wins over simultaneous start
    run_op(FN_ADD, 32'd2, 32'd1, lat, bok);
    tick();
    alu_funct = FN_ADD; data_rs = 32'd4; data_rt = 32'd4; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst-prio done", 64'(done),    64'd0);
    chk("rst-prio res",  64'(alu_res), 64'd0);
    tick();
    chk("rst-prio no late done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the core_lapido execute stage. It adds a start/busy/done handshake and iterative unsigned multiply, divide and remainder to the combinational ALU. Single-cycle operations return a result one cycle after issue. MUL/DIVU/REMU run a shift-add or restoring-division loop over WIDTH cycles while the pipeline stalls on `busy`.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 8
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  issue request; sampled only when `busy` = 0
- alu_funct  in  6  operation; `FN_*` codes from the shared core defines header
- data_rs  in  WIDTH  first operand
- data_rt  in  WIDTH  second operand / shift amount (`rt[$clog2(WIDTH)-1:0]`)
- busy  out  1  multi-cycle operation in progress; new `start` ignored
- done  out  1  one-cycle pulse: `alu_res`/`flags` updated this cycle
- alu_res  out  WIDTH+1  result; bit WIDTH is carry/extension bit
- flags  out  5  [0] Z, [1] N, [2] V, [3] DZ (divide by zero), [4] ILL (illegal funct)

## Operation
- States: IDLE, RUN, FIN. Reset → IDLE. On reset, `busy`, `done`, `alu_res` and `flags` are all 0.
- In IDLE (or FIN) with `start`=1, operands and funct are latched. Inputs are ignored after that edge until the next accept.
- **Single-cycle ops** (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, and illegal codes):
  - The result is registered on the accept edge.
  - The state goes to FIN, where `done`=1.
- **MUL, DIVU, REMU**:
  - The state goes to RUN. A count register is loaded with WIDTH-1.
  - One iteration per cycle in RUN; the count decrements each cycle.
  - When the count reaches 0, the final result is registered and the state goes to FIN.
- FIN lasts exactly one cycle. It then returns to IDLE, or accepts a new `start` directly, so back-to-back issue is allowed.
- **ADD**: `alu_res` = {carry, rs+rt}. V = signed overflow.
- **SUB**: rs + ~rt + 1. Bit WIDTH = carry out (1 ⇔ rs ≥ rt unsigned). V = signed overflow.
- **Logic ops and shifts**: bit WIDTH = 0, V = 0. SRA sign-extends.
- **SLT/SLTU**: `alu_res` = 1 or 0 (signed/unsigned compare). Bit WIDTH = 0.
- **MUL**: unsigned. `alu_res[WIDTH-1:0]` = low half of the product. Bit WIDTH = 1 iff the high half ≠ 0.
- **DIVU/REMU**: unsigned restoring division. The result is the quotient or remainder. Bit WIDTH = 0.
- **rt = 0 (DIVU/REMU)**: still takes the full latency. DIVU gives quotient = all ones; REMU gives remainder = rs. DZ = 1.
- **Illegal funct**: `alu_res` = 0, ILL = 1, single-cycle latency.
- **Z and N**: always computed from `alu_res[WIDTH-1:0]`. Z = all zero; N = bit WIDTH-1.
- **DZ and ILL**: 0 unless set as described above.
- **Output hold**: `alu_res` and `flags` hold their value between `done` pulses.

## Timing
- Start accepted at edge T:
  - single-cycle op: `done`=1 in cycle T+1; `busy` never asserts.
  - MUL/DIVU/REMU: `busy`=1 for cycles T+1 … T+WIDTH; `done`=1 at T+WIDTH+1 (latency WIDTH+1).
- `busy`=0 in the FIN cycle, so a `start` there is accepted. The next `done` then follows at the normal latency.
- `start` while `busy`=1 is dropped. It is not queued, and no `done` is generated for it.
- Changing operands or funct during RUN has no effect on the result.
- `rst` asserted in any state (including mid-RUN) aborts the operation:
  - next cycle: IDLE, all outputs 0, no `done` for the aborted op;
  - `rst` has priority over a simultaneous `start`.
- `done` is never high for two consecutive cycles unless back-to-back single-cycle starts were accepted.

## Test plan
- **Reset then ADD**: rst 2 cycles, then ADD rs=2, rt=1 → `done` at T+1, `alu_res`=33'h0_0000_0003, flags=0, `busy` stays 0.
- **SUB and ADD carry**:
  - SUB rs=2, rt=1 → `alu_res`=33'h1_0000_0001.
  - SUB rs=1, rt=2 → `alu_res`=33'h0_FFFF_FFFF, N=1.
  - ADD rs=32'h7FFF_FFFF, rt=1 → `alu_res`=33'h0_8000_0000, V=1, N=1.
- **MUL**:
  - rs=32'h0001_0000, rt=32'h0001_0000 → `busy` 32 cycles, `done` at T+33, `alu_res`=33'h1_0000_0000, Z=1.
  - rs=7, rt=6 → 42.
- **DIVU/REMU**:
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - DIVU 5/0 → 32'hFFFF_FFFF, DZ=1.
  - REMU 5/0 → 5, DZ=1.
  - All of these at latency 33.
- **Handshake**:
  - `start` during `busy`, with changed operands → ignored; result unchanged.
  - New `start` in the FIN cycle → accepted; second `done` on schedule.
- **Reset mid-DIVU and illegal funct**:
  - rst at cycle 10 of a DIVU → no `done`, outputs 0.
  - Illegal funct → `done` at T+1, `alu_res`=0, ILL=1, Z=1.
